// File: rtl/lvds_to_parallel.sv
// 7:1 LVDS receiver: deserialises three data lanes, aligns to the clock-lane
// 1110001 pattern, and recovers RGB/hsync/vsync/de once frame lock is held.
`timescale 1ns/1ps

module lvds_to_parallel #(
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 2
) (
  input  logic       lvdsInputClock,
  input  logic       resetN,
  input  logic       lvdsIn1,
  input  logic       lvdsIn2,
  input  logic       lvdsIn3,
  input  logic       lvdsClockIn,
  output logic [7:0] rgbOut,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       wordValid,
  output logic       locked
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Slot i of the clock lane lands in shift bit i once slot 6 is sampled.
  localparam logic [6:0] CLK_PATTERN = 7'b1000111;
  localparam logic [3:0] LOCK_N      = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N    = 4'(UNLOCK_FRAMES);
  localparam logic [2:0] LAST_PHASE  = 3'd6;

  state_e     state_q, state_d;
  logic [6:0] sh1_q, sh1_d;
  logic [6:0] sh2_q, sh2_d;
  logic [6:0] sh3_q, sh3_d;
  logic [6:0] shc_q, shc_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;

  logic match;
  logic expected;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign match    = (shc_q == CLK_PATTERN);
  assign expected = (phase_q == LAST_PHASE);

  // NOTE: every next-state signal gets its default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    sh1_d    = {lvdsIn1, sh1_q[6:1]};
    sh2_d    = {lvdsIn2, sh2_q[6:1]};
    sh3_d    = {lvdsIn3, sh3_q[6:1]};
    shc_d    = {lvdsClockIn, shc_q[6:1]};
    phase_d  = expected ? 3'd0 : phase_q + 3'd1;
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    valid_d  = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (match) begin
          state_d = VERIFY;
          phase_d = 3'd0;
          good_d  = 4'd0;
        end
      end

      VERIFY: begin
        if (expected) begin
          if (match) begin
            phase_d = 3'd0;
            good_d  = sat_inc(good_q);
            if (good_d == LOCK_N) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end else begin
            state_d = SEARCH;
          end
        end
      end

      LOCKED: begin
        if (expected) begin
          if (match) begin
            phase_d = 3'd0;
            bad_d   = 4'd0;
            valid_d = 1'b1;
            rgb_d   = {sh3_q[3], sh3_q[4], sh3_q[5], sh2_q[2], sh2_q[3],
                       sh1_q[1], sh1_q[2], sh1_q[3]};
            hsync_d = sh3_q[2];
            vsync_d = sh3_q[1];
            de_d    = sh3_q[0];
          end else begin
            // A missed boundary keeps the old word; the link may still recover.
            bad_d = sat_inc(bad_q);
            if (bad_d == UNLOCK_N) begin
              state_d = SEARCH;
            end
          end
        end
      end

      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge lvdsInputClock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= SEARCH;
      sh1_q    <= '0;
      sh2_q    <= '0;
      sh3_q    <= '0;
      shc_q    <= '0;
      phase_q  <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      sh3_q    <= sh3_d;
      shc_q    <= shc_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign rgbOut    = rgb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign wordValid = valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_lvds_to_parallel.sv
// Directed bench for lvds_to_parallel: lock acquisition, data mapping,
// glitch tolerance, bit slip and asynchronous reset.
`timescale 1ns/1ps

module tb_lvds_to_parallel;

  logic       clk = 1'b0;
  logic       resetN;
  logic       lvdsIn1, lvdsIn2, lvdsIn3, lvdsClockIn;
  logic [7:0] rgbOut;
  logic       hsync, vsync, de, wordValid, locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Observations taken at the sample after slot 0 of the latest frame, i.e.
  // the result of the previous frame's boundary.
  logic        p_wv, p_lk;
  logic [10:0] p_word;
  int          f_wv_cnt;

  localparam logic [6:0] CLK_GOOD = 7'b1000111;
  localparam logic [6:0] CLK_BAD  = 7'b0000000;

  lvds_to_parallel #(.LOCK_FRAMES(4), .UNLOCK_FRAMES(2)) dut (
    .lvdsInputClock(clk),
    .resetN        (resetN),
    .lvdsIn1       (lvdsIn1),
    .lvdsIn2       (lvdsIn2),
    .lvdsIn3       (lvdsIn3),
    .lvdsClockIn   (lvdsClockIn),
    .rgbOut        (rgbOut),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .wordValid     (wordValid),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_slot(input logic l1, input logic l2, input logic l3, input logic lc);
    @(negedge clk);
    lvdsIn1     = l1;
    lvdsIn2     = l2;
    lvdsIn3     = l3;
    lvdsClockIn = lc;
    @(posedge clk);
    #1;
  endtask

  // Don't-care lane bits carry random junk so a mis-mapped output shows up.
  task automatic send_frame(input logic [7:0] rgb, input logic d, input logic hs,
                            input logic vs, input logic [6:0] cp);
    logic [6:0] a, b, c;
    a = {3'b000, rgb[0], rgb[1], rgb[2], 1'b0} | (7'($urandom) & 7'b1110001);
    b = {3'b000, rgb[3], rgb[4], 2'b00}        | (7'($urandom) & 7'b1110011);
    c = {1'b0, rgb[5], rgb[6], rgb[7], hs, vs, d} | (7'($urandom) & 7'b1000000);
    f_wv_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      send_slot(a[i], b[i], c[i], cp[i]);
      if (wordValid) f_wv_cnt++;
      if (i == 0) begin
        p_wv   = wordValid;
        p_lk   = locked;
        p_word = {rgbOut, hsync, vsync, de};
      end
    end
  endtask

  // From SEARCH: frame 1 enters VERIFY, frames 2..5 verify, lock seen after
  // frame 5, first word (frame 6) seen after frame 7.
  task automatic run_lock(input logic [7:0] rgb, input logic d, input logic hs, input logic vs);
    for (int k = 1; k <= 5; k++) begin
      send_frame(rgb, d, hs, vs, CLK_GOOD);
      check("lock_not_early", {31'd0, p_lk}, 32'd0);
    end
    send_frame(rgb, d, hs, vs, CLK_GOOD);
    check("lock_rise", {31'd0, p_lk}, 32'd1);
    check("lock_frame_not_output", 32'(f_wv_cnt), 32'd0);
    send_frame(rgb, d, hs, vs, CLK_GOOD);
    check("first_word_valid", {31'd0, p_wv}, 32'd1);
    check("first_word_data", {21'd0, p_word}, {21'd0, rgb, hs, vs, d});
  endtask

  logic [10:0] walk [11];

  initial begin
    resetN = 1'b0;
    lvdsIn1 = 1'b0; lvdsIn2 = 1'b0; lvdsIn3 = 1'b0; lvdsClockIn = 1'b0;

    // Scenario 1: reset then lock
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {20'd0, rgbOut, hsync, vsync, de, wordValid, locked}, 32'd0);
    @(negedge clk) resetN = 1'b1;
    run_lock(8'hA5, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, CLK_GOOD);
    check("periodic_wv_count", 32'(f_wv_cnt), 32'd1);
    check("periodic_wv_slot0", {31'd0, p_wv}, 32'd1);

    // Scenario 2: stream starts mid-frame (slots 4..6)
    @(negedge clk) resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    send_slot(1'b1, 1'b0, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 1'b1, 1'b0);
    send_slot(1'b1, 1'b1, 1'b0, 1'b1);
    run_lock(8'h3C, 1'b0, 1'b1, 1'b0);

    // Scenario 3: walking ones on rgb, then each sync bit alone
    for (int i = 0; i < 8; i++) walk[i] = 11'(1) << (i + 3);
    walk[8]  = 11'b000_0000_0100;
    walk[9]  = 11'b000_0000_0010;
    walk[10] = 11'b000_0000_0001;
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) send_frame(walk[i][10:3], walk[i][0], walk[i][2], walk[i][1], CLK_GOOD);
      else        send_frame(8'h00, 1'b0, 1'b0, 1'b0, CLK_GOOD);
      if (i > 0) begin
        check("walk_wv_count", 32'(f_wv_cnt), 32'd1);
        check("walk_word", {21'd0, p_word}, {21'd0, walk[i-1]});
      end
    end

    // Scenario 4: single corrupt frame tolerated, two drop lock
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, CLK_GOOD);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, CLK_BAD);
    check("pre_glitch_word", {21'd0, p_word}, {21'd0, 8'h5A, 1'b1, 1'b0, 1'b1});
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, CLK_GOOD);
    check("glitch_no_wv", 32'(f_wv_cnt), 32'd0);
    check("glitch_hold", {21'd0, p_word}, {21'd0, 8'h5A, 1'b1, 1'b0, 1'b1});
    check("glitch_still_locked", {31'd0, p_lk}, 32'd1);
    send_frame(8'h69, 1'b1, 1'b0, 1'b0, CLK_GOOD);
    check("post_glitch_wv", {31'd0, p_wv}, 32'd1);
    check("post_glitch_word", {21'd0, p_word}, {21'd0, 8'h96, 1'b0, 1'b1, 1'b0});
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, CLK_BAD);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, CLK_BAD);
    check("first_bad_keeps_lock", {31'd0, p_lk}, 32'd1);
    check("first_bad_no_wv", {31'd0, p_wv}, 32'd0);
    run_lock(8'h81, 1'b1, 1'b0, 1'b0);

    // Scenario 5: one extra bit slips the phase
    send_frame(8'h24, 1'b1, 1'b1, 1'b1, CLK_GOOD);
    send_slot(1'b1, 1'b0, 1'b1, 1'b1);
    check("pre_slip_wv", {31'd0, wordValid}, 32'd1);
    check("pre_slip_word", {21'd0, rgbOut, hsync, vsync, de}, {21'd0, 8'h24, 3'b111});
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    check("slip_bad1_locked", {31'd0, locked}, 32'd1);
    check("slip_n1_no_wv", 32'(f_wv_cnt), 32'd0);
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    check("slip_bad2_unlocked", {31'd0, locked}, 32'd0);
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    check("slip_hold_after_loss", {21'd0, p_word}, {21'd0, 8'h24, 3'b111});
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, CLK_GOOD);
    check("slip_relock_not_early", {31'd0, locked}, 32'd0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, CLK_GOOD);
    check("slip_relock", {31'd0, p_lk}, 32'd1);
    check("slip_relock_no_wv", 32'(f_wv_cnt), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, CLK_GOOD);
    check("slip_word_valid", {31'd0, p_wv}, 32'd1);
    check("slip_word", {21'd0, p_word}, {21'd0, 8'hC3, 1'b1, 1'b0, 1'b1});

    // Scenario 6: asynchronous reset between edges while locked
    check("pre_reset_locked", {31'd0, locked}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("async_reset_clears", {20'd0, rgbOut, hsync, vsync, de, wordValid, locked}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    run_lock(8'hE7, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
